hot_addr_topk: RTL
==================

Name: hot_addr_topk

Overview:
- Consumer of the count-min sketch output stream (valid, addr, estimated count).
- Maintains a sorted top-K table of the hottest addresses, ordered by descending estimated count.
- On request, drains a snapshot of the table over a valid/ready stream to the page-migration / sorted-CAM logic.
- Sits directly downstream of the sketch top. It never back-pressures the sketch.

Parameters:
K, 8, number of table entries (>=2)
ADDR_SIZE, 22, address width; matches sketch
CNT_SIZE, 32, count width; matches sketch
RANK_SIZE, $clog2(K), rank index width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
input_valid  in  1  sketch result valid
input_addr  in  ADDR_SIZE  sketch address
input_cnt  in  CNT_SIZE  sketch min count
clear_req  in  1  pulse; empty the live table
dump_req  in  1  pulse; snapshot and drain the table
out_valid  out  1  dump entry valid
out_ready  in  1  consumer accepts
out_addr  out  ADDR_SIZE  dump address
out_cnt  out  CNT_SIZE  dump count
out_rank  out  RANK_SIZE  0 = hottest
out_last  out  1  final dump entry
dump_busy  out  1  dump FSM not IDLE
table_count  out  RANK_SIZE+1  live valid entries

Behaviour:
- Reset (rst sampled high at a clk edge):
  - All entries invalid, addr/cnt 0.
  - FSM IDLE.
  - All outputs 0.
- Live table invariants:
  - Entries 0..table_count-1 are valid; all higher entries are invalid.
  - Valid entries have non-increasing cnt.
  - No duplicate addresses.
- Update is single-cycle: input sampled at edge N becomes visible at edge N+1. Full throughput of one input per cycle.
- Hit (addr matches valid entry h):
  - new = max(stored, input_cnt).
  - p = number of valid entries j≠h with cnt >= new.
  - If p<h: entries p..h-1 shift down by one, and the hit entry is written at p.
  - Otherwise the entry stays at h with cnt updated.
- Miss:
  - p = number of valid entries with cnt >= input_cnt.
  - Table not full: insert at p, shift p..count-1 down, count+1.
  - Table full and p<K: insert at p, shift down, the old entry K-1 is evicted.
  - Table full and p==K (cnt <= min): drop.
- Ties: the incumbent keeps the higher rank.
- Every input is either a hit or a miss; there is no third case.
- clear_req:
  - Live table empties next cycle.
  - An input_valid in the same cycle is dropped.
  - clear_req does not affect a dump in progress.
- Dump FSM states:
  - IDLE: dump_req with table_count>0 → copy live table (pre-update value of the same cycle) into snapshot registers, go to SEND with idx=0. dump_req with table_count==0 → stay IDLE; nothing is emitted.
  - SEND: out_valid=1 and out_* = snapshot[idx]. out_last = (idx == snap_count-1). On out_valid&&out_ready: if last → IDLE, else idx+1. Outputs hold stable while out_ready=0.
  - dump_req while in SEND is ignored.
- dump_req and clear_req in the same cycle: the snapshot holds the pre-clear contents.
- Live updates continue during SEND and never alter the snapshot.
- dump_busy = (state != IDLE).
- Reset mid-dump: returns to IDLE with out_valid=0 on the next cycle.
- Counts are stored at full CNT_SIZE; there is no arithmetic, so no saturation is needed.

Decomposition:
- Package hot_topk_pkg:
  - topk_entry_t struct {valid, addr, cnt}.
  - dump_state_e {IDLE, SEND}.
  - Width localparams.
- Sub-module hot_topk_dump: snapshot registers plus the SEND FSM/handshake, fed from the live table array.
- Insert-position and shift logic stays in the top as comparator/priority loops.

Test Plan (K=4):
- Inputs A/10, B/30, C/20, then dump, out_ready=1 → ranks 0..2 = B/30, C/20, A/10; out_last on rank 2; dump_busy low one cycle after the last handshake.
- Fill A/10, B/20, C/30, D/40. Then E/5 → dropped. Then E/15 → table D/40, C/30, B/20, E/15 (A evicted).
- Hit promotion: table D/40, C/30, B/20, A/10. Input A/35 → D/40, A/35, C/30, B/20. Then input A/20 (lower) → A stays 35 and ranks are unchanged.
- Tie: table X/50. Input Y/50 → X rank 0, Y rank 1.
- Dump with out_ready toggled 1/0 while inputs F/100 stream every cycle → the emitted sequence equals the pre-dump snapshot, outputs are stable during stalls, and a later dump shows F/100 at rank 0.
- Edge cases:
  - clear_req together with input G/9 → table_count=0 next cycle.
  - dump_req on an empty table → no out_valid.
  - dump_req+clear_req in the same cycle → full old table dumped.
  - rst asserted mid-SEND → out_valid=0 and table_count=0 next cycle.

Source files
------------

// File: rtl/hot_topk_pkg.sv
// Shared types and widths for the hot-address top-K tracker.
// The entry struct uses the package widths; the top's ADDR_SIZE/CNT_SIZE must match them.
package hot_topk_pkg;

    localparam int TOPK_ADDR_SIZE = 22;
    localparam int TOPK_CNT_SIZE  = 32;

    typedef struct packed {
        logic                      valid;
        logic [TOPK_ADDR_SIZE-1:0] addr;
        logic [TOPK_CNT_SIZE-1:0]  cnt;
    } topk_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

    function automatic logic [TOPK_CNT_SIZE-1:0] cnt_max(
        input logic [TOPK_CNT_SIZE-1:0] a,
        input logic [TOPK_CNT_SIZE-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hot_topk_dump.sv
// Snapshot registers and valid/ready drain FSM for the top-K table.
// Outputs are registered and loaded from the snapshot on each accepted beat.
import hot_topk_pkg::*;

module hot_topk_dump #(
    parameter int K         = 8,
    parameter int ADDR_SIZE = TOPK_ADDR_SIZE,
    parameter int CNT_SIZE  = TOPK_CNT_SIZE,
    parameter int RANK_SIZE = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dump_req,
    input  topk_entry_t          live_tbl [K],
    input  logic [RANK_SIZE:0]   live_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic [CNT_SIZE-1:0]  out_cnt,
    output logic [RANK_SIZE-1:0] out_rank,
    output logic                 out_last,
    output logic                 dump_busy
);

    localparam int RW = RANK_SIZE + 1;

    dump_state_e          state_r, state_s;
    topk_entry_t          snap_r [K];
    logic [RANK_SIZE:0]   snap_count_r;
    logic [RANK_SIZE-1:0] idx_r, idx_s;
    logic                 load_s;
    logic                 out_valid_r, out_valid_s;
    logic [ADDR_SIZE-1:0] out_addr_r, out_addr_s;
    logic [CNT_SIZE-1:0]  out_cnt_r, out_cnt_s;
    logic                 out_last_r, out_last_s;

    // State, index and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_cnt_r   <= '0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_cnt_r   <= out_cnt_s;
            out_last_r  <= out_last_s;
        end
    end

    // Snapshot capture; holds the pre-update live table of the request cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                snap_r[i] <= '0;
            end
            snap_count_r <= '0;
        end else if (load_s) begin
            snap_r       <= live_tbl;
            snap_count_r <= live_count;
        end else begin
            snap_r       <= snap_r;
            snap_count_r <= snap_count_r;
        end
    end

    // Next state and next output beat.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        load_s      = 1'b0;
        out_valid_s = out_valid_r;
        out_addr_s  = out_addr_r;
        out_cnt_s   = out_cnt_r;
        out_last_s  = out_last_r;
        case (state_r)
            IDLE: begin
                if (dump_req && (live_count != RW'(0))) begin
                    state_s     = SEND;
                    load_s      = 1'b1;
                    idx_s       = '0;
                    out_valid_s = live_tbl[0].valid;
                    out_addr_s  = live_tbl[0].addr;
                    out_cnt_s   = live_tbl[0].cnt;
                    out_last_s  = (live_count == RW'(1));
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            SEND: begin
                if (out_valid_r && out_ready) begin
                    if (out_last_r) begin
                        state_s     = IDLE;
                        idx_s       = '0;
                        out_valid_s = 1'b0;
                        out_addr_s  = '0;
                        out_cnt_s   = '0;
                        out_last_s  = 1'b0;
                    end else begin
                        idx_s       = idx_r + RANK_SIZE'(1);
                        out_valid_s = snap_r[idx_s].valid;
                        out_addr_s  = snap_r[idx_s].addr;
                        out_cnt_s   = snap_r[idx_s].cnt;
                        out_last_s  = ({1'b0, idx_s} == (snap_count_r - RW'(1)));
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_cnt   = out_cnt_r;
    assign out_rank  = idx_r;
    assign out_last  = out_last_r;
    assign dump_busy = (state_r != IDLE);

endmodule

// File: rtl/hot_addr_topk.sv
// Sorted top-K table of the hottest sketch addresses, updated one input per cycle,
// with a snapshot drain port. Never back-pressures the sketch.
import hot_topk_pkg::*;

module hot_addr_topk #(
    parameter int K         = 8,
    parameter int ADDR_SIZE = TOPK_ADDR_SIZE,
    parameter int CNT_SIZE  = TOPK_CNT_SIZE,
    parameter int RANK_SIZE = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    input  logic [ADDR_SIZE-1:0] input_addr,
    input  logic [CNT_SIZE-1:0]  input_cnt,
    input  logic                 clear_req,
    input  logic                 dump_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic [CNT_SIZE-1:0]  out_cnt,
    output logic [RANK_SIZE-1:0] out_rank,
    output logic                 out_last,
    output logic                 dump_busy,
    output logic [RANK_SIZE:0]   table_count
);

    localparam int RW = RANK_SIZE + 1;
    localparam logic [RANK_SIZE:0] K_CNT = RW'(K);

    topk_entry_t         tbl_r [K];
    topk_entry_t         tbl_s [K];
    logic [RANK_SIZE:0]  count_r, count_s;
    logic                hit_s;
    logic [RANK_SIZE:0]  hit_idx_s;
    logic [CNT_SIZE-1:0] stored_cnt_s;
    logic [CNT_SIZE-1:0] new_cnt_s;
    logic [RANK_SIZE:0]  pos_s;
    logic                promote_s;
    topk_entry_t         new_entry_s;

    // Hit search, merged count and target position among the other valid entries.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < K; i++) begin
            hit_idx_s = (tbl_r[i].valid && (tbl_r[i].addr == input_addr)) ? RW'(i) : hit_idx_s;
            hit_s     = hit_s | (tbl_r[i].valid && (tbl_r[i].addr == input_addr));
        end
        stored_cnt_s = tbl_r[hit_idx_s[RANK_SIZE-1:0]].cnt;
        new_cnt_s    = hit_s ? cnt_max(stored_cnt_s, input_cnt) : input_cnt;
        // ">=" keeps incumbents ahead of an equal newcomer.
        pos_s = '0;
        for (int i = 0; i < K; i++) begin
            pos_s = pos_s + ((tbl_r[i].valid && (tbl_r[i].cnt >= new_cnt_s) &&
                              !(hit_s && (hit_idx_s == RW'(i)))) ? RW'(1) : RW'(0));
        end
        promote_s   = hit_s && (pos_s < hit_idx_s);
        new_entry_s = '{valid: 1'b1, addr: input_addr, cnt: new_cnt_s};
    end

    // Next live table: shift-down insert, in-place hit update, or clear.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            if (clear_req) begin
                tbl_s[i] = '0;
            end else if (!input_valid) begin
                tbl_s[i] = tbl_r[i];
            end else if (hit_s && promote_s) begin
                if (RW'(i) == pos_s) begin
                    tbl_s[i] = new_entry_s;
                end else if ((RW'(i) > pos_s) && (RW'(i) <= hit_idx_s)) begin
                    tbl_s[i] = tbl_r[(i > 0) ? i - 1 : 0];
                end else begin
                    tbl_s[i] = tbl_r[i];
                end
            end else if (hit_s) begin
                tbl_s[i] = (RW'(i) == hit_idx_s) ? new_entry_s : tbl_r[i];
            end else if (pos_s < K_CNT) begin
                if (RW'(i) == pos_s) begin
                    tbl_s[i] = new_entry_s;
                end else if (RW'(i) > pos_s) begin
                    tbl_s[i] = tbl_r[(i > 0) ? i - 1 : 0];
                end else begin
                    tbl_s[i] = tbl_r[i];
                end
            end else begin
                tbl_s[i] = tbl_r[i];
            end
        end
        if (clear_req) begin
            count_s = '0;
        end else if (input_valid && !hit_s && (pos_s < K_CNT) && (count_r < K_CNT)) begin
            count_s = count_r + RW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Live table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                tbl_r[i] <= '0;
            end
            count_r <= '0;
        end else begin
            tbl_r   <= tbl_s;
            count_r <= count_s;
        end
    end

    hot_topk_dump #(
        .K         (K),
        .ADDR_SIZE (ADDR_SIZE),
        .CNT_SIZE  (CNT_SIZE),
        .RANK_SIZE (RANK_SIZE)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .live_tbl   (tbl_r),
        .live_count (count_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_cnt    (out_cnt),
        .out_rank   (out_rank),
        .out_last   (out_last),
        .dump_busy  (dump_busy)
    );

    assign table_count = count_r;

endmodule
